// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I instruction-fetch stage: FSM states, IF/ID payload, helpers.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } ifid_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds by default, loads a new word, or collapses to a NOP bubble.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    // A bubble keeps pc/pc4 so the register still names the last fetched address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
            q.pc    <= '0;
            q.pc4   <= '0;
        end else if (bubble) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_inst,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_buf_q, fetch_buf_d;
    logic [XLEN-1:0] pc_inc;
    logic            req_c;
    logic [XLEN-1:0] addr_c;
    logic            ifid_load;
    logic            ifid_bubble;
    ifid_t           ifid_d;
    ifid_t           ifid_q;

    assign pc_inc = pc_q + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            fetch_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_buf_q <= fetch_buf_d;
        end
    end

    // Next state, PC, IF/ID control and the back-to-back request path.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_buf_d = fetch_buf_q;
        req_c       = 1'b0;
        addr_c      = word_align(pc_q);
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = {1'b1, imem_rdata, pc_q, pc_inc};

        if (redirect) begin
            ifid_bubble = 1'b1;
            pc_d        = word_align(redirect_pc);
            // An in-flight response must be drained before the new path may request.
            if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    req_c       = 1'b1;
                    state_d     = ST_WAIT;
                    ifid_bubble = !stall;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            fetch_buf_d = imem_rdata;
                            state_d     = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_inc;
                            req_c     = 1'b1;
                            addr_c    = word_align(pc_inc);
                        end
                    end else begin
                        ifid_bubble = !stall;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_d.inst = fetch_buf_q;
                        ifid_load   = 1'b1;
                        pc_d        = pc_inc;
                        req_c       = 1'b1;
                        addr_c      = word_align(pc_inc);
                        state_d     = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    ifid_bubble = !stall;
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    assign imem_req  = req_c & rst;
    assign imem_addr = addr_c;

    fetch_stage_if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .bubble(ifid_bubble),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign ifid_valid = ifid_q.valid;
    assign ifid_inst  = ifid_q.inst;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_pc4   = ifid_q.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with hand-written reset corner sequence.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NVEC = 22;

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;

    int checks;
    int errors;
    vec_t vecs[NVEC];

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_inst  (ifid_inst),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic rv, input logic [31:0] rd,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] inst,
                                input logic [31:0] pc, input logic [31:0] pc4);
        vec_t t;
        t.stall = s; t.redirect = r; t.rpc = rpc; t.rvalid = rv; t.rdata = rd;
        t.req = req; t.addr = addr; t.v = v; t.inst = inst; t.pc = pc; t.pc4 = pc4;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_ifid(input int idx, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [31:0] pc4);
        chk("ifid_valid", idx, 32'(ifid_valid), 32'(v));
        chk("ifid_inst", idx, ifid_inst, inst);
        chk("ifid_pc", idx, ifid_pc, pc);
        chk("ifid_pc4", idx, ifid_pc4, pc4);
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic rv, input logic [31:0] rd);
        stall = s; redirect = r; redirect_pc = rpc; imem_rvalid = rv; imem_rdata = rd;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //            stall redir rpc           rv  rdata          req addr          v  inst          pc            pc4
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, NOP,          32'h0,        32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 32'h4,        1'b0, NOP,          32'h0,        32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h00A00113, 1'b1, 32'h8,        1'b1, 32'h00500093, 32'h0,        32'h4);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h002081B3, 1'b0, 32'h0,        1'b1, 32'h00A00113, 32'h4,        32'h8);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00A00113, 32'h4,        32'h8);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h00A00113, 32'h4,        32'h8);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h00A00113, 32'h4,        32'h8);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h002081B3, 32'h8,        32'hC);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,          32'h8,        32'hC);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h40110133, 1'b1, 32'h10,       1'b0, NOP,          32'h8,        32'hC);
        vecs[10] = mk(1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40110133, 32'hC,        32'h10);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0, NOP,          32'hC,        32'h10);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, NOP,          32'hC,        32'h10);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100,      1'b0, NOP,          32'hC,        32'h10);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h00300193, 1'b1, 32'h104,      1'b0, NOP,          32'hC,        32'h10);
        vecs[15] = mk(1'b1, 1'b1, 32'h103,      1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h00300193, 32'h100,      32'h104);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h100,      1'b0, NOP,          32'h100,      32'h104);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h22222213, 1'b1, 32'h104,      1'b0, NOP,          32'h100,      32'h104);
        vecs[18] = mk(1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h22222213, 32'h100,      32'h104);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, NOP,          32'h100,      32'h104);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h44444413, 1'b1, 32'h0,        1'b0, NOP,          32'h100,      32'h104);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44444413, 32'hFFFFFFFC, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_req", -1, 32'(imem_req), 32'h0);
        chk_ifid(-1, 1'b0, NOP, 32'h0, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].rvalid, vecs[i].rdata);
            #1;
            chk("imem_req", i, 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk("imem_addr", i, imem_addr, vecs[i].addr);
            chk_ifid(i, vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].pc4);
        end

        // Reset asserted while a fetch to 0x0 is outstanding; its late response must be ignored.
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst_req_low", 100, 32'(imem_req), 32'h0);
        @(negedge clk);
        #1;
        chk("rst_req_low", 101, 32'(imem_req), 32'h0);
        chk_ifid(101, 1'b0, NOP, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0BAD0);
        #1;
        chk("post_rst_req", 102, 32'(imem_req), 32'h1);
        chk("post_rst_addr", 102, imem_addr, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("late_rvalid_req", 103, 32'(imem_req), 32'h0);
        chk_ifid(103, 1'b0, NOP, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00500093);
        #1;
        chk("refetch_req", 104, 32'(imem_req), 32'h1);
        chk("refetch_addr", 104, imem_addr, 32'h4);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk_ifid(105, 1'b1, 32'h00500093, 32'h0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
